// File: rtl/serial_tx_packetizer.sv
// Packet FIFO feeding a UART serialiser: optional header, payload words in selectable order,
// optional modulo checksum, all sent as back-to-back 8N1-style frames.
module serial_tx_packetizer #(
  parameter int unsigned          WordWidth         = 8,
  parameter int unsigned          Words             = 4,
  parameter int unsigned          QueueAddressWidth = 3,
  parameter int unsigned          DivWidth          = 16,
  parameter bit                   MsbWordFirst      = 1'b1,
  parameter bit                   HeaderEnable      = 1'b1,
  parameter logic [WordWidth-1:0] HeaderValue       = 'h7E,
  parameter bit                   ChecksumEnable    = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic [Words*WordWidth-1:0]   i_data,
  input  logic [DivWidth-1:0]          i_div,
  output logic                         o_tx,
  output logic                         o_busy,
  output logic                         o_void,
  output logic                         o_overflow,
  output logic                         o_sent
);

  localparam int unsigned PktWidth   = Words * WordWidth;
  localparam int unsigned Depth      = 2 ** QueueAddressWidth;
  localparam int unsigned FrameWidth = $clog2(Words + 3);
  localparam int unsigned BitWidth   = $clog2(WordWidth + 1);
  localparam int unsigned HdrFrames  = HeaderEnable ? 1 : 0;
  localparam int unsigned CsFrames   = ChecksumEnable ? 1 : 0;

  localparam logic [QueueAddressWidth:0] DepthL   = (QueueAddressWidth + 1)'(Depth);
  localparam logic [FrameWidth-1:0]      FramesL  = FrameWidth'(Words + HdrFrames + CsFrames);
  localparam logic [FrameWidth-1:0]      PayEndL  = FrameWidth'(Words + HdrFrames);
  localparam logic [BitWidth-1:0]        LastBitL = BitWidth'(WordWidth - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;

  logic [PktWidth-1:0]          r_mem [Depth];
  logic [QueueAddressWidth-1:0] r_wr_ptr, r_rd_ptr;
  logic [QueueAddressWidth:0]   r_count;
  logic                         r_busy, r_overflow, r_sent;
  logic [2:0]                   r_state;
  logic [DivWidth-1:0]          r_div, r_cnt;
  logic [BitWidth-1:0]          r_bit;
  logic [FrameWidth-1:0]        r_frame;
  logic [PktWidth-1:0]          r_shift;
  logic [WordWidth-1:0]         r_word, r_csum;

  logic                         w_push, w_pop, w_bit_end, w_enter_start;
  logic                         w_is_header, w_is_payload;
  logic [QueueAddressWidth:0]   w_count_d;
  logic [WordWidth-1:0]         w_pay_word, w_next_word;

  // Fullness is the registered flag, so a same-cycle pop never rescues a push.
  assign w_push    = i_ce & ~r_busy;
  assign w_pop     = (r_state == StIdle) && (r_count != '0);
  assign w_bit_end = (r_cnt == r_div);
  assign w_enter_start = (r_state == StLoad) ||
                         ((r_state == StStop) && w_bit_end && (r_frame != FramesL));

  assign w_is_header  = HeaderEnable && (r_frame == '0);
  assign w_is_payload = !w_is_header && (r_frame < PayEndL);
  assign w_pay_word   = MsbWordFirst ? r_shift[PktWidth-1 -: WordWidth] : r_shift[WordWidth-1:0];
  assign w_next_word  = w_is_header ? HeaderValue : (w_is_payload ? w_pay_word : r_csum);

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + (QueueAddressWidth + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - (QueueAddressWidth + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_busy     <= (w_count_d == DepthL);
      r_overflow <= i_ce & r_busy;
      if (w_push) r_wr_ptr <= r_wr_ptr + QueueAddressWidth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + QueueAddressWidth'(1);
    end
  end

  // The pop cycle already clears the frame index and checksum, so the load cycle can
  // select frame 0 and arm the first start bit in one step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_frame <= '0;
      r_csum  <= '0;
      r_word  <= '0;
      r_div   <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_frame <= '0;
      r_csum  <= '0;
    end else if (w_enter_start) begin
      r_div   <= i_div;
      r_word  <= w_next_word;
      r_frame <= r_frame + FrameWidth'(1);
      if (w_is_payload) begin
        r_csum  <= r_csum + w_pay_word;
        r_shift <= MsbWordFirst ? (r_shift << WordWidth) : (r_shift >> WordWidth);
      end
    end else if ((r_state == StData) && w_bit_end) begin
      r_word <= r_word >> 1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sent  <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      case (r_state)
        StIdle: if (w_pop) r_state <= StLoad;
        StLoad: begin
          r_state <= StStart;
          r_cnt   <= '0;
        end
        StStart: begin
          if (w_bit_end) begin
            r_state <= StData;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + DivWidth'(1);
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == LastBitL) r_state <= StStop;
            else                   r_bit   <= r_bit + BitWidth'(1);
          end else begin
            r_cnt <= r_cnt + DivWidth'(1);
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_frame == FramesL) begin
              r_state <= StIdle;
              r_sent  <= 1'b1;
            end else begin
              r_state <= StStart;
            end
          end else begin
            r_cnt <= r_cnt + DivWidth'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Combinational from the async-reset state so the line goes high the moment rst asserts.
  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      StStart: o_tx = 1'b0;
      StData:  o_tx = r_word[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy     = r_busy;
  assign o_void     = (r_state == StIdle) && (r_count == '0);
  assign o_overflow = r_overflow;
  assign o_sent     = r_sent;

endmodule

// File: doc/serial_tx_packetizer.md
# serial_tx_packetizer

Queued multi-word packet transmitter with an integrated UART serialiser. Each accepted packet is a `Words*WordWidth` vector. It is sent as consecutive UART frames:

- an optional header word,
- the payload words in a selectable order,
- an optional modulo checksum word.

The block is fully synchronous, with a runtime-programmable bit period. It is the successor to the fixed 2^n-word serial packet transmitter and sits between result-producing cores and the host UART link.

## Interface
- `WordWidth`, 8, bits per UART frame and per payload word (1..16).
- `Words`, 4, payload words per packet (1..256; not restricted to powers of two).
- `QueueAddressWidth`, 3, packet queue depth = 2**QueueAddressWidth.
- `DivWidth`, 16, width of the bit-period input.
- `MsbWordFirst`, 1, 1: word 0 = `data[Words*WordWidth-1 -: WordWidth]` is sent first; 0: the least significant word is sent first.
- `HeaderEnable`, 1, prepend the header frame.
- `HeaderValue`, 'h7E, header word (WordWidth wide).
- `ChecksumEnable`, 1, append the checksum frame.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  push request: enqueue `data` at this edge.
- `data`  in  Words*WordWidth  packet payload.
- `div`  in  DivWidth  bit period minus one, in clocks.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  queue full.
- `void`  out  1  queue empty and serialiser idle.
- `overflow`  out  1  one-clock pulse: a push was dropped.
- `sent`  out  1  one-clock pulse: last stop bit of a packet completed.

## Operation
- **Queue:** FIFO of whole packets.
  - A push with `busy`=1 is dropped and pulses `overflow`. Fullness is evaluated before any same-cycle pop, so a pop in that cycle does not rescue the push.
  - Push and pop in the same cycle on a non-full queue: both take effect; the count is unchanged.
- **FSM states:** IDLE, LOAD, START, DATA, STOP.
  - IDLE: if the queue is non-empty, pop and go to LOAD.
  - LOAD: capture the packet into a shift register, clear the frame index and the checksum accumulator, then go to START.
  - START: drive `tx`=0 for one bit period.
  - DATA: send WordWidth bits, LSB first, one bit period each.
  - STOP: drive `tx`=1 for one bit period. Then:
    - if frames remain, go to START;
    - otherwise pulse `sent` and go to IDLE.
- **Bit period:** `div+1` clocks. `div` is sampled only on entry to START and held for the whole frame. `div`=0 gives one clock per bit.
- **Frame sequence:** [header] + Words payload frames + [checksum]. Frames within a packet are back-to-back, with no idle clocks between them.
- **Checksum:** sum of the payload words mod 2**WordWidth. The header is excluded.
- **Packet gap:** consecutive packets are separated by exactly 2 high clocks (the IDLE and LOAD cycles).
- **Reset values:** `tx`=1, `busy`=0, `void`=1, `overflow`=0, `sent`=0. Queue pointers, counters and FSM are cleared to IDLE.
- **Reset mid-frame:** `tx` returns high immediately (asynchronously). Queued packets and the packet in flight are discarded.

## Timing
- **Push-to-line latency:** with the block idle, a push sampled at edge E0 makes the queue non-empty after E0. The pop occurs at E1 (IDLE→LOAD), and `tx` falls at E2.
- **Frame duration:** (WordWidth+2)*(div+1) clocks.
- **Packet duration:** (Words + HeaderEnable + ChecksumEnable) × frame duration.
- **`sent`:** high for the single clock after the final stop bit ends. The FSM is in IDLE in that clock.
- **`busy`:** registered. It is high in the clock after the push that fills the queue, and falls in the clock after the first pop from full.
- **`void`:** high only when the FSM is in IDLE and the queue is empty. It falls at the edge that accepts a push.

## Test plan
- `div`=3, defaults, push `32'h11223344`: frames 7E,11,22,33,44,AA; 40 clocks each; `tx` low at E2; 240 clocks later `sent` pulses once and `void`=1.
- Depth 8, `ce` held for 10 consecutive clocks with distinct packets:
  - `busy` rises after the 9th push;
  - the 10th push is dropped with one `overflow` pulse;
  - 9 packets go out in push order, each separated by exactly 2 idle clocks.
- `MsbWordFirst`=0, `HeaderEnable`=0, `ChecksumEnable`=0, push `32'h11223344`: frames 44,33,22,11 only.
- Checksum wrap: payload FF,FF,FF,FF gives checksum frame FC.
- `div` changed from 3 to 1 mid-DATA: the current frame completes at 4 clocks/bit; the next start bit runs at 2 clocks/bit.
- `rst` pulsed during the data bits of payload word 2 with 3 packets queued:
  - `tx`=1 immediately, `void`=1, no further frames;
  - after release, a new push transmits a clean full packet.
